fetch_unit: RTL and testbench

- Front-end fetch stage that sits directly upstream of the synchronous instruction cache. It owns the PC, issues one-word read requests to the cache and captures the returned word one cycle later.
- Returned words are buffered in a small in-order fetch queue of {pc, instr} pairs and presented to decode over a valid/ready handshake.
- Supports pipeline redirect (branch/jump/exception) with flush of the queue and squash of the in-flight cache response.

---
 rtl/fetch_unit.sv | 107 ++++++++++
 tb/tb_fetch_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: front-end fetch stage in front of a synchronous instruction cache.
// It owns the PC, issues one-word reads, captures each returned word one cycle
// later, and buffers {pc, instr} pairs in an in-order queue that decode drains
// over a valid/ready handshake. A redirect flushes the queue and squashes the
// in-flight cache response.
//
// Ports:
//   clk, rst                   clock; synchronous active-high reset
//   redirect_valid/redirect_pc redirect request and new PC (bits [1:0] ignored)
//   ic_en/ic_addr              cache read request (combinational) and address
//   ic_rdata/ic_rvalid         cache response, one cycle after ic_en
//   out_valid/out_ready        head-entry handshake to decode
//   out_pc/out_instr           head-entry PC and instruction word
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned FQ_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        ic_en,
    output logic [31:0] ic_addr,
    input  logic [31:0] ic_rdata,
    input  logic        ic_rvalid,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr
);

    localparam int unsigned PW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam logic [PW:0]   FULL    = (PW+1)'(FQ_DEPTH);
    localparam logic [PW+1:0] CREDITS = (PW+2)'(FQ_DEPTH);

    logic [31:0]   pc;
    logic          inflight;
    logic [31:0]   inflight_pc;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;

    logic [31:0] pc_mem    [FQ_DEPTH];
    logic [31:0] instr_mem [FQ_DEPTH];

    logic          push;
    logic          pop;
    logic [PW+1:0] credit_used;

    // An in-flight request already owns a queue slot; a same-cycle pop does
    // not return credit, so every response is guaranteed somewhere to land.
    assign credit_used = {1'b0, count} + {{(PW+1){1'b0}}, inflight};
    assign ic_en       = !rst && !redirect_valid && (credit_used < CREDITS);
    assign ic_addr     = pc;

    // A response without a matching request is ignored; a missing response
    // simply drops that entry and its credit frees up when inflight clears.
    assign push = !rst && !redirect_valid && inflight && ic_rvalid;

    assign out_valid = (count != '0) && !redirect_valid;
    assign pop       = out_valid && out_ready;
    assign out_pc    = (count != '0) ? pc_mem[rd_ptr]    : '0;
    assign out_instr = (count != '0) ? instr_mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC & ~32'h3;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else if (redirect_valid) begin
            // Flush by snapping rd_ptr to wr_ptr; the pending response is
            // squashed because inflight is cleared.
            pc       <= redirect_pc & ~32'h3;
            inflight <= 1'b0;
            count    <= '0;
            rd_ptr   <= wr_ptr;
        end else begin
            inflight <= ic_en;
            if (ic_en) begin
                pc          <= pc + 32'd4;
                inflight_pc <= pc;
            end
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)
                count <= count + (PW+1)'(1);
            else if (pop && !push)
                count <= count - (PW+1)'(1);
        end
    end

    // Storage carries no reset; out_pc/out_instr are masked while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= inflight_pc;
            instr_mem[wr_ptr] <= ic_rdata;
        end
    end

    a_no_push_when_full: assert property (
        @(posedge clk) disable iff (rst) push |-> (count != FULL)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit. Stimulus pushes expected
// {pc, instr} pairs into a queue per DUT; a negedge monitor pops and compares
// on every accepted output. Instance A uses RESET_PC=0, instance B uses
// RESET_PC=FFFF_FFF8 to exercise PC wrap. Cache word at address a is
// 0x1000_0000 + (a >> 2).
module tb_fetch_unit;

    logic        clk = 1'b0;
    int          checks = 0;
    int          failures = 0;

    // Instance A
    logic        rst_a = 1'b1, redirect_valid_a = 1'b0, out_ready_a = 1'b0;
    logic [31:0] redirect_pc_a = '0;
    logic        ic_en_a, out_valid_a;
    logic [31:0] ic_addr_a, out_pc_a, out_instr_a;
    logic [31:0] ic_rdata_a = '0;
    logic        ic_rvalid_a = 1'b0;
    logic        bad100 = 1'b0;
    int          pops_a = 0;
    logic [63:0] exp_a [$];

    // Instance B
    logic        rst_b = 1'b1, out_ready_b = 1'b1;
    logic        ic_en_b, out_valid_b;
    logic [31:0] ic_addr_b, out_pc_b, out_instr_b;
    logic [31:0] ic_rdata_b = '0;
    logic        ic_rvalid_b = 1'b0;
    int          pops_b = 0;
    logic [63:0] exp_b [$];

    fetch_unit #(.RESET_PC(32'h0000_0000), .FQ_DEPTH(4)) dut_a (
        .clk(clk), .rst(rst_a),
        .redirect_valid(redirect_valid_a), .redirect_pc(redirect_pc_a),
        .ic_en(ic_en_a), .ic_addr(ic_addr_a),
        .ic_rdata(ic_rdata_a), .ic_rvalid(ic_rvalid_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a),
        .out_pc(out_pc_a), .out_instr(out_instr_a)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FQ_DEPTH(4)) dut_b (
        .clk(clk), .rst(rst_b),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .ic_en(ic_en_b), .ic_addr(ic_addr_b),
        .ic_rdata(ic_rdata_b), .ic_rvalid(ic_rvalid_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b),
        .out_pc(out_pc_b), .out_instr(out_instr_b)
    );

    initial forever #5 clk = ~clk;

    // Synchronous cache models
    always @(posedge clk) begin
        ic_rvalid_a <= ic_en_a;
        if (ic_en_a) ic_rdata_a <= 32'h1000_0000 + (ic_addr_a >> 2);
        if (ic_en_a && ic_addr_a == 32'h0000_0100) bad100 <= 1'b1;
        ic_rvalid_b <= ic_en_b;
        if (ic_en_b) ic_rdata_b <= 32'h1000_0000 + (ic_addr_b >> 2);
    end

    // Monitors
    always @(negedge clk) begin
        logic [63:0] e;
        if (out_valid_a && out_ready_a) begin
            pops_a++;
            checks++;
            if (exp_a.size() == 0) begin
                failures++;
                $display("FAIL sb_a unexpected pop pc=%h instr=%h", out_pc_a, out_instr_a);
            end else begin
                e = exp_a.pop_front();
                if ({out_pc_a, out_instr_a} !== e) begin
                    failures++;
                    $display("FAIL sb_a actual pc=%h instr=%h required pc=%h instr=%h",
                             out_pc_a, out_instr_a, e[63:32], e[31:0]);
                end
            end
        end
        if (out_valid_b && out_ready_b) begin
            pops_b++;
            checks++;
            if (exp_b.size() == 0) begin
                failures++;
                $display("FAIL sb_b unexpected pop pc=%h instr=%h", out_pc_b, out_instr_b);
            end else begin
                e = exp_b.pop_front();
                if ({out_pc_b, out_instr_b} !== e) begin
                    failures++;
                    $display("FAIL sb_b actual pc=%h instr=%h required pc=%h instr=%h",
                             out_pc_b, out_instr_b, e[63:32], e[31:0]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic load_seq(input logic [31:0] start, input int n);
        logic [31:0] p;
        for (int i = 0; i < n; i++) begin
            p = start + 32'(4 * i);
            exp_a.push_back({p, 32'h1000_0000 + (p >> 2)});
        end
    endtask

    initial begin
        int p0;

        // Reset, then continuous drain
        out_ready_a = 1'b1;
        step();
        chk("rst_ic_en", 32'(ic_en_a), 0);
        chk("rst_out_valid", 32'(out_valid_a), 0);
        chk("rst_out_pc", out_pc_a, 0);
        chk("rst_out_instr", out_instr_a, 0);
        load_seq(32'h0, 16);
        rst_a = 1'b0;
        p0 = pops_a;
        step();
        chk("fill_valid_t1", 32'(out_valid_a), 0);
        chk("fill_ic_en_t1", 32'(ic_en_a), 1);
        chk("fill_ic_addr_t1", ic_addr_a, 32'h4);
        step();
        chk("fill_valid_t2", 32'(out_valid_a), 1);
        chk("fill_pc_t2", out_pc_a, 32'h0);
        repeat (9) step();
        out_ready_a = 1'b0;
        chk("stream_pops", 32'(pops_a - p0), 9);
        exp_a.delete();

        // Backpressure: queue fills to 4, then drains without gaps
        rst_a = 1'b1;
        step();
        load_seq(32'h0, 16);
        rst_a = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (i == 3) chk("bp_ic_en_open", 32'(ic_en_a), 1);
            if (i >= 4) chk("bp_ic_en_closed", 32'(ic_en_a), 0);
        end
        chk("bp_out_valid", 32'(out_valid_a), 1);
        chk("bp_head_pc", out_pc_a, 32'h0);
        chk("bp_ic_addr", ic_addr_a, 32'h10);
        p0 = pops_a;
        out_ready_a = 1'b1;
        repeat (12) step();
        out_ready_a = 1'b0;
        chk("bp_drain_pops", 32'(pops_a - p0), 12);
        exp_a.delete();

        // Redirect with 3 queued + 1 in flight
        load_seq(32'h40, 16);
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        repeat (4) step();
        redirect_valid_a = 1'b1;
        redirect_pc_a = 32'h0000_0043;
        #1;
        chk("redir_out_valid", 32'(out_valid_a), 0);
        chk("redir_ic_en", 32'(ic_en_a), 0);
        step();
        redirect_valid_a = 1'b0;
        out_ready_a = 1'b1;
        p0 = pops_a;
        chk("redir_valid_t1", 32'(out_valid_a), 0);
        step();
        chk("redir_valid_t2", 32'(out_valid_a), 0);
        chk("redir_ic_addr_t2", ic_addr_a, 32'h44);
        step();
        chk("redir_valid_t3", 32'(out_valid_a), 1);
        chk("redir_pc_t3", out_pc_a, 32'h40);
        repeat (5) step();
        out_ready_a = 1'b0;
        chk("redir_pops", 32'(pops_a - p0), 5);
        exp_a.delete();

        // Back-to-back redirects: last one wins
        load_seq(32'h200, 16);
        redirect_valid_a = 1'b1;
        redirect_pc_a = 32'h100;
        step();
        redirect_pc_a = 32'h200;
        step();
        redirect_valid_a = 1'b0;
        out_ready_a = 1'b1;
        p0 = pops_a;
        repeat (8) step();
        out_ready_a = 1'b0;
        chk("b2b_pops", 32'(pops_a - p0), 6);
        chk("b2b_no_fetch_100", 32'(bad100), 0);
        exp_a.delete();

        // Reset with 2 queued + 1 in flight
        load_seq(32'h0, 16);
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        repeat (3) step();
        rst_a = 1'b1;
        step();
        chk("midrst_out_valid", 32'(out_valid_a), 0);
        chk("midrst_ic_en", 32'(ic_en_a), 0);
        rst_a = 1'b0;
        #1;
        chk("midrst_restart_en", 32'(ic_en_a), 1);
        chk("midrst_restart_addr", ic_addr_a, 32'h0);
        out_ready_a = 1'b1;
        p0 = pops_a;
        repeat (8) step();
        out_ready_a = 1'b0;
        chk("midrst_pops", 32'(pops_a - p0), 6);

        // PC wrap on instance B
        exp_b.push_back({32'hFFFF_FFF8, 32'h4FFF_FFFE});
        exp_b.push_back({32'hFFFF_FFFC, 32'h4FFF_FFFF});
        exp_b.push_back({32'h0000_0000, 32'h1000_0000});
        chk("wrap_rst_pc", ic_addr_b, 32'hFFFF_FFF8);
        rst_b = 1'b0;
        p0 = pops_b;
        repeat (5) step();
        out_ready_b = 1'b0;
        chk("wrap_pops", 32'(pops_b - p0), 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
